// File: rtl/memory_arbiter_pkg.sv
// rtl/memory_arbiter_pkg.sv - shared types and line geometry for the memory arbiter
package memory_arbiter_pkg;

  localparam int LINE_BITS        = 256;
  localparam int LINE_OFFSET_BITS = 5;

  typedef enum logic [1:0] {
    IDLE,
    BUSY_IC,
    BUSY_DC,
    RELEASE
  } arb_state_e;

  typedef enum logic {
    REQ_IC,
    REQ_DC
  } arb_req_e;

endpackage

// File: rtl/memory_arbiter_if.sv
// rtl/memory_arbiter_if.sv - cache and memory side signals of the memory arbiter
interface memory_arbiter_if #(
  parameter int ADDR_BITS = 32,
  parameter int LINE_BITS = 256
);

  logic                 ic_read;
  logic [ADDR_BITS-1:0] ic_address;
  logic                 ic_ready;
  logic [LINE_BITS-1:0] ic_rdata;

  logic                 dc_read;
  logic                 dc_write;
  logic [ADDR_BITS-1:0] dc_address;
  logic [LINE_BITS-1:0] dc_wdata;
  logic                 dc_ready;
  logic [LINE_BITS-1:0] dc_rdata;
  logic                 dc_done;

  logic                 mem_read;
  logic                 mem_write;
  logic [ADDR_BITS-1:0] mem_address;
  logic [LINE_BITS-1:0] mem_wdata;
  logic [LINE_BITS-1:0] mem_rdata;
  logic                 mem_ready;
  logic                 mem_done;

  logic                 timeout;

  // slave: the arbiter itself; master: caches plus memory around it
  modport slave (
    input  ic_read, ic_address, dc_read, dc_write, dc_address, dc_wdata,
           mem_rdata, mem_ready, mem_done,
    output ic_ready, ic_rdata, dc_ready, dc_rdata, dc_done,
           mem_read, mem_write, mem_address, mem_wdata, timeout
  );

  modport master (
    output ic_read, ic_address, dc_read, dc_write, dc_address, dc_wdata,
           mem_rdata, mem_ready, mem_done,
    input  ic_ready, ic_rdata, dc_ready, dc_rdata, dc_done,
           mem_read, mem_write, mem_address, mem_wdata, timeout
  );

endinterface

// File: rtl/memory_arbiter_rr_arbiter2.sv
// rtl/memory_arbiter_rr_arbiter2.sv - combinational two-way round-robin pick
module memory_arbiter_rr_arbiter2
  import memory_arbiter_pkg::*;
(
  input  logic     req_ic,
  input  logic     req_dc,
  input  arb_req_e last_grant,
  output logic     grant_valid,
  output arb_req_e grant
);

  always_comb begin
    grant_valid = req_ic | req_dc;
    grant       = REQ_IC;
    if (req_ic && req_dc) begin
      grant = (last_grant == REQ_IC) ? REQ_DC : REQ_IC;
    end else if (req_dc) begin
      grant = REQ_DC;
    end
  end

endmodule

// File: rtl/memory_arbiter.sv
// rtl/memory_arbiter.sv - shares one line-wide memory port between I-cache and D-cache
module memory_arbiter #(
  parameter int ADDR_BITS      = 32,
  parameter int LINE_BITS      = memory_arbiter_pkg::LINE_BITS,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input logic              clock,
  input logic              reset,
  memory_arbiter_if.slave  bus
);

  import memory_arbiter_pkg::*;

  localparam int WD_BITS = $clog2(TIMEOUT_CYCLES);
  localparam logic [WD_BITS-1:0] WD_MAX = WD_BITS'(TIMEOUT_CYCLES - 1);

  function automatic logic [ADDR_BITS-1:0] line_align(input logic [ADDR_BITS-1:0] a);
    return {a[ADDR_BITS-1:LINE_OFFSET_BITS], {LINE_OFFSET_BITS{1'b0}}};
  endfunction

  arb_state_e           state_q, state_d;
  arb_req_e             last_grant_q, grant;
  logic                 grant_valid;
  logic [WD_BITS-1:0]   wd_q;
  logic                 op_write_q, abandoned_q;
  logic                 do_grant, do_complete, do_expire;
  logic                 busy, mem_complete, still_req, abandoned_now;

  logic                 ic_ready_q, dc_ready_q, dc_done_q, timeout_q;
  logic                 mem_read_q, mem_write_q;
  logic [ADDR_BITS-1:0] mem_address_q;
  logic [LINE_BITS-1:0] mem_wdata_q, ic_rdata_q, dc_rdata_q;

  memory_arbiter_rr_arbiter2 u_rr (
    .req_ic      (bus.ic_read),
    .req_dc      (bus.dc_read | bus.dc_write),
    .last_grant  (last_grant_q),
    .grant_valid (grant_valid),
    .grant       (grant)
  );

  assign busy         = (state_q == BUSY_IC) || (state_q == BUSY_DC);
  assign mem_complete = op_write_q ? bus.mem_done : bus.mem_ready;

  // A requester that lets go at any point during BUSY forfeits its response pulse
  always_comb begin
    still_req = 1'b0;
    if (state_q == BUSY_IC) begin
      still_req = bus.ic_read;
    end else if (state_q == BUSY_DC) begin
      still_req = op_write_q ? bus.dc_write : bus.dc_read;
    end
  end
  assign abandoned_now = abandoned_q | ~still_req;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    do_grant    = 1'b0;
    do_complete = 1'b0;
    do_expire   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (grant_valid) begin
          do_grant = 1'b1;
          state_d  = (grant == REQ_IC) ? BUSY_IC : BUSY_DC;
        end
      end
      BUSY_IC, BUSY_DC: begin
        if (mem_complete) begin
          do_complete = 1'b1;
          state_d     = RELEASE;
        end else if (wd_q == WD_MAX) begin
          do_expire = 1'b1;
          state_d   = RELEASE;
        end
      end
      RELEASE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      last_grant_q  <= REQ_DC;
      wd_q          <= '0;
      op_write_q    <= 1'b0;
      abandoned_q   <= 1'b0;
      ic_ready_q    <= 1'b0;
      dc_ready_q    <= 1'b0;
      dc_done_q     <= 1'b0;
      timeout_q     <= 1'b0;
      mem_read_q    <= 1'b0;
      mem_write_q   <= 1'b0;
      mem_address_q <= '0;
      mem_wdata_q   <= '0;
      ic_rdata_q    <= '0;
      dc_rdata_q    <= '0;
    end else begin
      ic_ready_q <= 1'b0;
      dc_ready_q <= 1'b0;
      dc_done_q  <= 1'b0;
      timeout_q  <= 1'b0;

      if (do_grant) begin
        last_grant_q <= grant;
        wd_q         <= '0;
        abandoned_q  <= 1'b0;
        if (grant == REQ_IC) begin
          op_write_q    <= 1'b0;
          mem_read_q    <= 1'b1;
          mem_write_q   <= 1'b0;
          mem_address_q <= line_align(bus.ic_address);
          mem_wdata_q   <= '0;
        end else begin
          // dc_write takes priority over a simultaneous (illegal) dc_read
          op_write_q    <= bus.dc_write;
          mem_read_q    <= ~bus.dc_write;
          mem_write_q   <= bus.dc_write;
          mem_address_q <= line_align(bus.dc_address);
          mem_wdata_q   <= bus.dc_write ? bus.dc_wdata : '0;
        end
      end

      if (busy) begin
        wd_q        <= wd_q + WD_BITS'(1);
        abandoned_q <= abandoned_now;
      end

      if (do_complete || do_expire) begin
        mem_read_q    <= 1'b0;
        mem_write_q   <= 1'b0;
        mem_address_q <= '0;
        mem_wdata_q   <= '0;
      end

      if (do_complete && !abandoned_now) begin
        if (state_q == BUSY_IC) begin
          ic_ready_q <= 1'b1;
          ic_rdata_q <= bus.mem_rdata;
        end else if (op_write_q) begin
          dc_done_q <= 1'b1;
        end else begin
          dc_ready_q <= 1'b1;
          dc_rdata_q <= bus.mem_rdata;
        end
      end

      if (do_expire) begin
        timeout_q <= 1'b1;
      end
    end
  end

  assign bus.ic_ready    = ic_ready_q;
  assign bus.ic_rdata    = ic_rdata_q;
  assign bus.dc_ready    = dc_ready_q;
  assign bus.dc_rdata    = dc_rdata_q;
  assign bus.dc_done     = dc_done_q;
  assign bus.mem_read    = mem_read_q;
  assign bus.mem_write   = mem_write_q;
  assign bus.mem_address = mem_address_q;
  assign bus.mem_wdata   = mem_wdata_q;
  assign bus.timeout     = timeout_q;

endmodule
